// File: rtl/eq_run_pkg.sv
// Shared types for the equal-sample run counter: FSM states and the
// per-sample event-selection mode.
package eq_run_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        TRACK = 1'b1
    } state_e;

    typedef enum logic {
        MODE_EQ  = 1'b0,
        MODE_CHG = 1'b1
    } mode_e;

endpackage

// File: rtl/eq_run_counter_sat_cnt.sv
// Saturating up-counter with synchronous clear and load-to-one.
// Priority is clr, then load1, then inc. The count never wraps.
module sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load1,
    input  logic         inc,
    output logic [W-1:0] value
);

    localparam logic [W-1:0] MAX = '1;
    localparam logic [W-1:0] ONE = W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (load1) begin
            value <= ONE;
        end else if (inc && (value != MAX)) begin
            value <= value + ONE;
        end
    end

endmodule

// File: rtl/eq_run_counter.sv
// Run/event statistics over a stream of samples: counts equal or changed
// samples, tracks the current and longest run, and pulses on a run threshold.
module eq_run_counter
    import eq_run_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int CNT_W  = 8,
    parameter int THRESH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             mode_i,
    output logic [CNT_W-1:0] event_cnt,
    output logic [CNT_W-1:0] run_len,
    output logic [CNT_W-1:0] max_run,
    output logic             run_hit_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] THR     = CNT_W'(THRESH);

    state_e           state;
    state_e           state_next;
    logic [WIDTH-1:0] prev;
    logic             eq;
    logic             evt;
    logic             evt_inc;
    logic             run_load1;
    logic             run_inc;
    logic [CNT_W-1:0] run_next;

    assign eq  = (data_i == prev);
    assign evt = (mode_e'(mode_i) == MODE_CHG) ? !eq : eq;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= EMPTY;
        end else if (clr_i) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // The first sample after reset/clear only seeds prev; comparisons start in TRACK.
    always_comb begin
        state_next = state;
        evt_inc    = 1'b0;
        run_load1  = 1'b0;
        run_inc    = 1'b0;
        run_next   = run_len;
        case (state)
            EMPTY: begin
                if (valid_i) begin
                    run_load1  = 1'b1;
                    run_next   = ONE;
                    state_next = TRACK;
                end
            end
            TRACK: begin
                if (valid_i) begin
                    evt_inc = evt;
                    if (eq) begin
                        run_inc  = 1'b1;
                        run_next = (run_len == CNT_MAX) ? run_len : run_len + ONE;
                    end else begin
                        run_load1 = 1'b1;
                        run_next  = ONE;
                    end
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    sat_cnt #(.W(CNT_W)) u_event_cnt (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .clr   (clr_i),
        .load1 (1'b0),
        .inc   (evt_inc),
        .value (event_cnt)
    );

    sat_cnt #(.W(CNT_W)) u_run_len (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .clr   (clr_i),
        .load1 (run_load1),
        .inc   (run_inc),
        .value (run_len)
    );

    // Hit requires run_len to move onto THRESH, so a run saturated at THRESH fires once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev      <= '0;
            max_run   <= '0;
            run_hit_o <= 1'b0;
        end else if (clr_i) begin
            prev      <= '0;
            max_run   <= '0;
            run_hit_o <= 1'b0;
        end else begin
            run_hit_o <= 1'b0;
            if (valid_i) begin
                prev      <= data_i;
                run_hit_o <= (run_next == THR) && (run_len != THR);
                if (run_next > max_run) begin
                    max_run <= run_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_eq_run_counter.sv
// Scoreboard bench for eq_run_counter: stimulus pushes reference-model
// expectations, a monitor pops and compares them after every clock edge.
module tb_eq_run_counter;

    localparam int WIDTH  = 4;
    localparam int CNT_W  = 8;
    localparam int THRESH = 4;
    localparam int SAT    = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [CNT_W-1:0] evt;
        logic [CNT_W-1:0] run;
        logic [CNT_W-1:0] mx;
        logic             hit;
    } exp_t;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic             clr_i = 1'b0;
    logic             valid_i = 1'b0;
    logic [WIDTH-1:0] data_i = '0;
    logic             mode_i = 1'b0;
    logic [CNT_W-1:0] event_cnt;
    logic [CNT_W-1:0] run_len;
    logic [CNT_W-1:0] max_run;
    logic             run_hit_o;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   hit_seen = 0;

    // Reference model state: sample history summarised as plain integers.
    bit               m_have = 0;
    logic [WIDTH-1:0] m_prev = '0;
    int               m_evt = 0;
    int               m_run = 0;
    int               m_max = 0;
    bit               m_hit = 0;

    eq_run_counter #(
        .WIDTH  (WIDTH),
        .CNT_W  (CNT_W),
        .THRESH (THRESH)
    ) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clr_i     (clr_i),
        .valid_i   (valid_i),
        .data_i    (data_i),
        .mode_i    (mode_i),
        .event_cnt (event_cnt),
        .run_len   (run_len),
        .max_run   (max_run),
        .run_hit_o (run_hit_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_output(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v >= SAT) ? SAT : v + 1;
    endfunction

    function automatic void model_step(input bit rst, input bit clr, input bit valid,
                                       input logic [WIDTH-1:0] d, input bit mode);
        int  old_run;
        int  new_run;
        bit  same;
        if (!rst || clr) begin
            m_have = 0;
            m_prev = '0;
            m_evt  = 0;
            m_run  = 0;
            m_max  = 0;
            m_hit  = 0;
        end else if (!valid) begin
            m_hit = 0;
        end else begin
            old_run = m_run;
            if (!m_have) begin
                new_run = 1;
            end else begin
                same = (d == m_prev);
                if (mode ? !same : same) m_evt = sat_inc(m_evt);
                new_run = same ? sat_inc(m_run) : 1;
            end
            m_have = 1;
            m_prev = d;
            m_run  = new_run;
            if (new_run > m_max) m_max = new_run;
            m_hit = (new_run == THRESH) && (old_run != THRESH);
        end
    endfunction

    // Drive one cycle of inputs and queue what the DUT must show after the next edge.
    task automatic apply_stimulus(input bit rst, input bit clr, input bit valid,
                                  input logic [WIDTH-1:0] d, input bit mode);
        exp_t e;
        logic was_out_of_reset;
        @(negedge clk_i);
        was_out_of_reset = rst_ni;
        rst_ni  = rst;
        clr_i   = clr;
        valid_i = valid;
        data_i  = d;
        mode_i  = mode;
        model_step(rst, clr, valid, d, mode);
        e.evt = CNT_W'(m_evt);
        e.run = CNT_W'(m_run);
        e.mx  = CNT_W'(m_max);
        e.hit = m_hit;
        exp_q.push_back(e);
        if (was_out_of_reset && !rst) begin
            #1;
            check_output("async_rst_event_cnt", int'(event_cnt), 0);
            check_output("async_rst_run_len", int'(run_len), 0);
            check_output("async_rst_max_run", int'(max_run), 0);
            check_output("async_rst_run_hit", int'(run_hit_o), 0);
        end
    endtask

    task automatic check_final(input string name, input int evt, input int run,
                               input int mx, input int hits);
        @(posedge clk_i);
        #2;
        check_output({name, "_event_cnt"}, int'(event_cnt), evt);
        check_output({name, "_run_len"}, int'(run_len), run);
        check_output({name, "_max_run"}, int'(max_run), mx);
        check_output({name, "_hits"}, hit_seen, hits);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk_i);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_output("event_cnt", int'(event_cnt), int'(e.evt));
                check_output("run_len", int'(run_len), int'(e.run));
                check_output("max_run", int'(max_run), int'(e.mx));
                check_output("run_hit", int'(run_hit_o), int'(e.hit));
                if (run_hit_o) hit_seen++;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [WIDTH-1:0] v;

        // Reset held with live samples on the inputs.
        for (int i = 0; i < 5; i++) apply_stimulus(0, 0, 1, WIDTH'($urandom), 0);

        hit_seen = 0;
        for (int i = 0; i < 10; i++) apply_stimulus(1, 0, 1, 4'h5, 0);
        check_final("const", 9, 10, 10, 1);

        apply_stimulus(1, 1, 0, '0, 0);
        hit_seen = 0;
        for (int i = 0; i < 32; i++) begin
            v = WIDTH'(i / 2);
            apply_stimulus(1, 0, 1, v, 0);
        end
        check_final("ramp_eq", 16, 2, 2, 0);

        apply_stimulus(1, 1, 0, '0, 0);
        hit_seen = 0;
        for (int i = 0; i < 32; i++) begin
            v = WIDTH'(i / 2);
            apply_stimulus(1, 0, 1, v, 1);
        end
        check_final("ramp_chg", 15, 2, 2, 0);
        for (int i = 0; i < 5; i++) apply_stimulus(1, 0, 0, WIDTH'($urandom), 0);
        check_final("idle", 15, 2, 2, 0);

        apply_stimulus(1, 1, 0, '0, 0);
        hit_seen = 0;
        for (int i = 0; i < 300; i++) apply_stimulus(1, 0, 1, 4'h9, 0);
        check_final("sat", 255, 255, 255, 1);

        apply_stimulus(1, 1, 0, '0, 0);
        hit_seen = 0;
        for (int i = 0; i < 6; i++) apply_stimulus(1, 0, 1, 4'h7, 0);
        apply_stimulus(1, 1, 1, 4'hA, 0);
        check_final("clear", 0, 0, 0, 1);
        apply_stimulus(1, 0, 1, 4'hA, 0);
        check_final("after_clear", 0, 1, 1, 1);

        for (int i = 0; i < 3; i++) apply_stimulus(1, 0, 1, 4'hA, 0);
        apply_stimulus(0, 0, 1, 4'hA, 0);
        apply_stimulus(0, 0, 1, 4'hA, 0);
        hit_seen = 0;
        apply_stimulus(1, 0, 1, 4'h3, 0);
        check_final("after_reset", 0, 1, 1, 0);

        // Random traffic with a narrow data range so runs of various lengths form.
        for (int i = 0; i < 500; i++) begin
            apply_stimulus(1, ($urandom_range(0, 99) < 3), ($urandom_range(0, 9) < 8),
                           WIDTH'($urandom_range(0, 2)), 1'($urandom));
        end
        apply_stimulus(1, 0, 0, '0, 0);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk_i);
        #2;
        check_output("drain", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/eq_run_counter.md
# eq_run_counter

Parametrised successor to the single-channel equal-sample counter. Each accepted sample is compared against the previous accepted sample. The block keeps a saturating event count, the length of the current run of identical samples, and the longest run seen so far, and it flags when a run reaches a threshold. The event being counted is either "equal to previous" or "changed from previous", selected per sample. It sits directly behind a sampled data source as a statistics/monitor block.

## Interface
- `WIDTH`, 4, data sample width (≥1)
- `CNT_W`, 8, width of all counters (≥2)
- `THRESH`, 4, run length that fires `run_hit_o` (1 ≤ THRESH ≤ 2^CNT_W−1)

- `clk_i`  in  1  clock; all state updates on rising edge
- `rst_ni`  in  1  asynchronous, active-low reset
- `clr_i`  in  1  synchronous clear of all state; has priority over `valid_i`
- `valid_i`  in  1  `data_i` is a sample this cycle
- `data_i`  in  WIDTH  sample
- `mode_i`  in  1  0 = count equal events, 1 = count change events; sampled with each valid sample
- `event_cnt`  out  CNT_W  saturating count of events
- `run_len`  out  CNT_W  length of the current run of identical samples, saturating
- `max_run`  out  CNT_W  largest `run_len` since reset/clear
- `run_hit_o`  out  1  one-cycle pulse when `run_len` becomes exactly THRESH

## Operation
- FSM states: EMPTY (no previous sample held) and TRACK.
- Reset, async: state EMPTY; `prev` = 0; `event_cnt`, `run_len`, `max_run`, `run_hit_o` all 0.
- `clr_i`=1: same effect as reset, applied at the clock edge. Any sample on `valid_i` in that cycle is discarded.
- EMPTY with `valid_i`:
  - `prev` ← `data_i`, `run_len` ← 1, `max_run` ← max(`max_run`, 1).
  - No comparison is made and `event_cnt` is unchanged.
  - State → TRACK.
  - If THRESH = 1, `run_hit_o` pulses.
- TRACK with `valid_i`: let eq = (`data_i` == `prev`).
  - The event is eq when `mode_i`=0, and !eq when `mode_i`=1. On an event, `event_cnt` increments, saturating at 2^CNT_W−1.
  - If eq: `run_len` ← `run_len`+1, saturating. Otherwise `run_len` ← 1.
  - `max_run` ← max(`max_run`, next `run_len`).
  - `prev` ← `data_i`.
- `valid_i`=0 and `clr_i`=0: all state holds and `run_hit_o` is 0.
- `run_hit_o` is registered. It is 1 in the cycle after the sample whose update makes next `run_len` == THRESH, and only when `run_len` != THRESH beforehand. It therefore fires at most once per run, including when THRESH = 2^CNT_W−1 and the counter saturates there.
- All counters use unsigned arithmetic in CNT_W bits. A saturated counter never wraps.

## Timing
- All outputs are registered. Latency is 1 cycle: effects of a sample at edge k are visible after edge k.
- Back-to-back valid samples are accepted every cycle. There is no backpressure.
- Simultaneous events:
  - `clr_i` and `valid_i` together: the clear wins.
  - A `mode_i` change affects only the sample it accompanies.
- Reset mid-operation: outputs go to 0 immediately (asynchronously), and the next valid sample is treated as the first sample.

## Structure
- Package `eq_run_pkg` holds:
  - the `state_e` enum (EMPTY, TRACK);
  - the `mode_e` enum (MODE_EQ = 0, MODE_CHG = 1).
- Sub-module `sat_cnt`, parametrised by width, with inputs clr, load1, inc and output value. It saturates at all-ones and is instantiated for `event_cnt` and `run_len`.
- `max_run` and the FSM stay in the top module.

## Test plan
1. **Reset:** `rst_ni` low for 5 cycles with random `data_i` and `valid_i`=1. Required: all outputs 0 throughout. Assert reset mid-run. Required: outputs 0 asynchronously, before the next edge.
2. **Constant input:** `data_i`=4'h5, `valid_i`=1 for 10 cycles, `mode_i`=0. Required: `event_cnt`=9, `run_len`=10, `max_run`=10, and `run_hit_o` high for exactly one cycle, after the 4th sample.
3. **Ramp, equal mode:** values 0..15, each held for 2 valid cycles (32 samples), `mode_i`=0. Required: `event_cnt`=16, `run_len`=2, `max_run`=2, `run_hit_o` never high.
4. **Ramp, change mode:** same stimulus as 3 with `mode_i`=1. Required: `event_cnt`=15. Then `valid_i`=0 for 5 cycles. Required: outputs unchanged.
5. **Saturation:** constant data for 300 samples, CNT_W=8. Required: `event_cnt`=255, `run_len`=255, `max_run`=255, exactly one `run_hit_o` pulse, no wrap.
6. **Clear:** 6 equal samples, then `clr_i`=1 together with `valid_i`=1 and new data 4'hA. Required: next cycle all outputs 0. The next sample 4'hA gives `run_len`=1 and `event_cnt`=0.
